display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Drives the processor's debug display path from the other end: generates the register-select code and enable for the display multiplexer, latches the 32-bit word returned on the hex-display bus, and time-multiplexes it onto eight active-low seven-segment digits. It sits between the board switches/LEDs and the processor's display port. It either auto-cycles through all display sources (PC, IR, RA, RB, RZ, RM, RY, RF_a/b/c, …) or holds a manually selected source.

## Interface
Parameters:
- NUM_SOURCES, 12: number of valid select codes, 0..NUM_SOURCES-1 (max 32).
- SETTLE_CYCLES, 2: wait cycles between driving a select and sampling HexDisplay (≥1).
- DWELL_CYCLES, 50_000_000: cycles a captured source is held before the next capture.
- DIGIT_CYCLES, 50_000: cycles each digit is lit during scanning.

Ports:
- Clock  in  1  system clock, rising edge.
- DisplayReset  in  1  synchronous, active-high reset.
- Auto_Enable  in  1  1 = auto-cycle sources; 0 = manual.
- Manual_Select  in  5  source code used in manual mode.
- HexDisplay  in  32  word returned by the display multiplexer.
- Display_Select  out  5  registered select code to the multiplexer.
- Display_Enable  out  1  registered enable to the multiplexer.
- Captured_Word  out  32  last latched HexDisplay value.
- Capture_Valid  out  1  one-cycle pulse when Captured_Word updates.
- Source_Index  out  5  index of the source currently held.
- Digit_Anode  out  8  one-hot active-low digit enable; bit i = nibble i.
- Segments  out  7  active-low {g,f,e,d,c,b,a}.

## Operation
- Capture FSM states: SELECT, SETTLE, CAPTURE, DWELL.
- SELECT (1 cycle): Display_Select, Source_Index <= index; Display_Enable <= 1.
- SETTLE: counts SETTLE_CYCLES cycles, then CAPTURE.
- CAPTURE (1 cycle): Captured_Word <= HexDisplay; Capture_Valid = 1 for exactly this cycle; then DWELL.
- DWELL: counts DWELL_CYCLES cycles, then computes the next index and returns to SELECT.
- Auto mode: next index = index+1; from NUM_SOURCES-1 it wraps to 0.
- Manual mode: index = Manual_Select, clamped to NUM_SOURCES-1 if out of range.
- Manual_Select is registered each cycle. In manual mode, a change in that registered copy during SETTLE or DWELL aborts the current state. The FSM enters SELECT on the next edge with the new index.
- Auto_Enable is sampled only at DWELL exit and at abort decisions. Toggling it mid-dwell takes effect at the next index computation.
- Digit scanner runs independently of the FSM:
  - A prescaler counts DIGIT_CYCLES.
  - At terminal count the digit index advances 0→7, then wraps to 0.
  - Segments decode nibble Captured_Word[4i+3:4i] for the lit digit i (hex 0–F).

## Timing
- Reset values:
  - Display_Select = 0, Source_Index = 0, Display_Enable = 0.
  - Captured_Word = 0, Capture_Valid = 0.
  - Digit_Anode = 8'hFE, Segments = 7'h40 (glyph "0").
  - FSM = SELECT, index = 0 (or the clamped Manual_Select in manual mode), all counters 0.
- Capture latency: Capture_Valid is high in cycle SETTLE_CYCLES+2 after the first edge with DisplayReset low. Cycle 1 = SELECT.
- Capture period with no abort: SETTLE_CYCLES+DWELL_CYCLES+2 cycles.
- Display_Select is stable from SELECT through CAPTURE. HexDisplay is sampled only in CAPTURE.
- Captured_Word changes only on a CAPTURE edge. The scanner therefore never shows a torn word, but a digit may show the new value mid-scan.
- Reset asserted mid-operation: all state returns to reset values on that edge. No partial capture is kept.

## Configuration
- DISPLAY_BLANK_LEADING_ZEROS_EN defined:
  - Digits above the most-significant non-zero nibble drive Segments = 7'h7F (blank).
  - Digit 0 is always shown, so a value of 0 displays a single "0".
  - Digit_Anode scanning is unchanged.
- Undefined: all eight digits always display their nibble.

## Test plan
All scenarios use SETTLE_CYCLES=2, DWELL_CYCLES=4, DIGIT_CYCLES=2, NUM_SOURCES=12.
- Reset release, Auto_Enable=1, HexDisplay=32'h0000_0101 → Display_Select=0 at cycle 1; Capture_Valid pulse in cycle 4 with Captured_Word=32'h0000_0101; Display_Select=1 at cycle 9.
- Auto run for 12 periods → Source_Index sequence 0..11, then 0 (wrap); exactly one Capture_Valid per period.
- Auto_Enable=0, Manual_Select=3 during DWELL, then changed to 20 → abort, SELECT next edge; Display_Select=3, then 11 (clamped); no Capture_Valid during the aborted dwell.
- Captured_Word=32'hAAAA_BBBB → Digit_Anode steps FE,FD,…,7F, one step every 2 cycles; Segments = "B" glyph for digits 0–3 and "A" glyph for digits 4–7.
- Captured_Word=32'h0000_2626 → with DISPLAY_BLANK_LEADING_ZEROS_EN, digits 4–7 show Segments=7'h7F; without it they show 7'h40.
- DisplayReset pulsed in SETTLE → next cycle all outputs at reset values; Captured_Word keeps 0 until the new capture in cycle 4 after release.

Source files
------------

// File: rtl/display_scan_controller.sv
// Selects display sources, latches the returned hex word and scans it onto eight seven-segment digits.
// Capture lands SETTLE_CYCLES+2 edges after reset release; no backpressure. Optional: DISPLAY_BLANK_LEADING_ZEROS_EN.
module display_scan_controller #(
    parameter int NUM_SOURCES   = 12,
    parameter int SETTLE_CYCLES = 2,
    parameter int DWELL_CYCLES  = 50_000_000,
    parameter int DIGIT_CYCLES  = 50_000
) (
    input  logic        i_clock,
    input  logic        i_display_reset,
    input  logic        i_auto_enable,
    input  logic [4:0]  i_manual_select,
    input  logic [31:0] i_hex_display,
    output logic [4:0]  o_display_select,
    output logic        o_display_enable,
    output logic [31:0] o_captured_word,
    output logic        o_capture_valid,
    output logic [4:0]  o_source_index,
    output logic [7:0]  o_digit_anode,
    output logic [6:0]  o_segments
);

    typedef enum logic [1:0] {ST_SELECT, ST_SETTLE, ST_CAPTURE, ST_DWELL} state_t;

    localparam logic [4:0]  LAST_SRC    = 5'(NUM_SOURCES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] DWELL_LAST  = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] DIGIT_LAST  = 32'(DIGIT_CYCLES - 1);

    function automatic logic [4:0] clamp_src(input logic [4:0] sel);
        return (sel > LAST_SRC) ? LAST_SRC : sel;
    endfunction

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [4:0]  r_index;
    logic [4:0]  r_manual_q;
    logic [4:0]  r_manual_prev;
    logic [4:0]  r_display_select;
    logic [4:0]  r_source_index;
    logic        r_display_enable;
    logic [31:0] r_captured_word;
    logic        r_capture_valid;
    logic [31:0] r_presc;
    logic [2:0]  r_digit;

    state_t      w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic [4:0]  w_index_nxt;
    logic [4:0]  w_next_index;
    logic        w_abort;
    logic [3:0]  w_nibble;
    logic [6:0]  w_glyph;

    // Auto mode walks the source list; manual mode follows the registered switch copy.
    assign w_next_index = i_auto_enable ? ((r_index >= LAST_SRC) ? 5'd0 : r_index + 5'd1)
                                        : clamp_src(r_manual_q);
    assign w_abort = !i_auto_enable && (r_manual_q != r_manual_prev)
                     && (r_state == ST_SETTLE || r_state == ST_DWELL);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_index_nxt = r_index;
        case (r_state)
            ST_SELECT: begin
                w_state_nxt = ST_SETTLE;
                w_cnt_nxt   = '0;
            end
            ST_SETTLE: begin
                if (w_abort) begin
                    w_state_nxt = ST_SELECT;
                    w_cnt_nxt   = '0;
                    w_index_nxt = clamp_src(r_manual_q);
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_CAPTURE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_DWELL;
                w_cnt_nxt   = '0;
            end
            ST_DWELL: begin
                if (w_abort || r_cnt == DWELL_LAST) begin
                    w_state_nxt = ST_SELECT;
                    w_cnt_nxt   = '0;
                    w_index_nxt = w_next_index;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_SELECT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_display_reset) begin
            r_state          <= ST_SELECT;
            r_cnt            <= '0;
            r_index          <= i_auto_enable ? 5'd0 : clamp_src(i_manual_select);
            r_manual_q       <= i_manual_select;
            r_manual_prev    <= i_manual_select;
            r_display_select <= '0;
            r_source_index   <= '0;
            r_display_enable <= 1'b0;
            r_captured_word  <= '0;
            r_capture_valid  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_index         <= w_index_nxt;
            r_manual_q      <= i_manual_select;
            r_manual_prev   <= r_manual_q;
            r_capture_valid <= (r_state == ST_CAPTURE);
            if (r_state == ST_SELECT) begin
                r_display_select <= r_index;
                r_source_index   <= r_index;
                r_display_enable <= 1'b1;
            end
            if (r_state == ST_CAPTURE) begin
                r_captured_word <= i_hex_display;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_display_reset) begin
            r_presc <= '0;
            r_digit <= '0;
        end else if (r_presc == DIGIT_LAST) begin
            r_presc <= '0;
            r_digit <= r_digit + 3'd1;
        end else begin
            r_presc <= r_presc + 32'd1;
        end
    end

    assign w_nibble = r_captured_word[{r_digit, 2'b00} +: 4];

    always_comb begin
        case (w_nibble)
            4'h0: w_glyph = 7'h40;
            4'h1: w_glyph = 7'h79;
            4'h2: w_glyph = 7'h24;
            4'h3: w_glyph = 7'h30;
            4'h4: w_glyph = 7'h19;
            4'h5: w_glyph = 7'h12;
            4'h6: w_glyph = 7'h02;
            4'h7: w_glyph = 7'h78;
            4'h8: w_glyph = 7'h00;
            4'h9: w_glyph = 7'h10;
            4'hA: w_glyph = 7'h08;
            4'hB: w_glyph = 7'h03;
            4'hC: w_glyph = 7'h46;
            4'hD: w_glyph = 7'h21;
            4'hE: w_glyph = 7'h06;
            default: w_glyph = 7'h0E;
        endcase
    end

`ifdef DISPLAY_BLANK_LEADING_ZEROS_EN
    logic [2:0] w_msn;

    // Digit 0 is never blanked, so a zero word still shows a single "0".
    always_comb begin
        w_msn = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (r_captured_word[4*i +: 4] != 4'h0) begin
                w_msn = 3'(i);
            end
        end
    end

    assign o_segments = (r_digit > w_msn) ? 7'h7F : w_glyph;
`else
    assign o_segments = w_glyph;
`endif

    assign o_digit_anode    = ~(8'b1 << r_digit);
    assign o_display_select = r_display_select;
    assign o_display_enable = r_display_enable;
    assign o_captured_word  = r_captured_word;
    assign o_capture_valid  = r_capture_valid;
    assign o_source_index   = r_source_index;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized scoreboard bench for display_scan_controller with an edge-offset reference model.
module tb_display_scan_controller;

    localparam int NS  = 12;
    localparam int S   = 2;
    localparam int D   = 4;
    localparam int DC  = 2;
    localparam int PER = S + D + 2;
    localparam int MAXE = 8192;

    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst;
    logic        auto_en;
    logic [4:0]  man;
    logic [31:0] hex;
    logic [4:0]  o_sel;
    logic        o_en;
    logic [31:0] o_word;
    logic        o_valid;
    logic [4:0]  o_idx;
    logic [7:0]  o_anode;
    logic [6:0]  o_seg;

    display_scan_controller #(
        .NUM_SOURCES(NS), .SETTLE_CYCLES(S), .DWELL_CYCLES(D), .DIGIT_CYCLES(DC)
    ) dut (
        .i_clock(clk), .i_display_reset(rst), .i_auto_enable(auto_en),
        .i_manual_select(man), .i_hex_display(hex),
        .o_display_select(o_sel), .o_display_enable(o_en), .o_captured_word(o_word),
        .o_capture_valid(o_valid), .o_source_index(o_idx),
        .o_digit_anode(o_anode), .o_segments(o_seg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          edge_n;
        logic [31:0] word;
        logic [4:0]  src;
    } cap_t;

    cap_t       capq[$];
    bit         rst_hist [MAXE];
    logic [4:0] man_hist [MAXE];
    int vectors = 0;
    int miscompares = 0;
    int sel_edge = 1;
    int cur_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int clamp(input logic [4:0] m);
        return (int'(m) > NS - 1) ? NS - 1 : int'(m);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [31:0] w, input int dig);
        int nib;
        nib = int'((w >> (4 * dig)) & 32'hF);
`ifdef DISPLAY_BLANK_LEADING_ZEROS_EN
        begin
            int top;
            top = 0;
            for (int i = 0; i < 8; i++)
                if (((w >> (4 * i)) & 32'hF) != 0) top = i;
            if (dig > top) return 7'h7F;
        end
`endif
        return GLYPH[nib];
    endfunction

    function automatic logic [31:0] pick_hex();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $urandom & 32'hFF;
            2: return 32'h0;
            default: return $urandom & 32'hFFFF;
        endcase
    endfunction

    // Model: each source occupies SELECT at offset 0, capture at S+1, leaves after S+1+D.
    task automatic step(input bit r, input bit a, input logic [4:0] m, input logic [31:0] h);
        int e, d;
        e = cyc + 1;
        rst = r; auto_en = a; man = m; hex = h;
        man_hist[e] = m;
        rst_hist[e] = r;
        if (r) begin
            sel_edge = e + 1;
            cur_idx  = a ? 0 : clamp(m);
        end else begin
            d = e - sel_edge;
            if (!a && ((d >= 1 && d <= S) || (d >= S + 2 && d <= S + 1 + D))
                && man_hist[e-1] != man_hist[e-2]) begin
                sel_edge = e + 1;
                cur_idx  = clamp(man_hist[e-1]);
            end else if (d == S + 1) begin
                capq.push_back('{e, h, 5'(cur_idx)});
            end else if (d == S + 1 + D) begin
                sel_edge = e + 1;
                cur_idx  = a ? (cur_idx + 1) % NS : clamp(man_hist[e-1]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    int          k = 0;
    bit          seen = 1'b0;
    logic [31:0] mword = 32'h0;

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXE) begin
            if (rst_hist[cyc]) begin
                seen  = 1'b1;
                k     = 0;
                mword = 32'h0;
                check("rst_select", 32'(o_sel), 32'h0);
                check("rst_index", 32'(o_idx), 32'h0);
                check("rst_enable", 32'(o_en), 32'h0);
                check("rst_valid", 32'(o_valid), 32'h0);
            end else if (seen) begin
                k++;
                check("enable", 32'(o_en), 32'h1);
                while (capq.size() > 0 && capq[0].edge_n < cyc) begin
                    check("missed_capture_at", 32'(capq[0].edge_n), 32'hFFFF_FFFF);
                    void'(capq.pop_front());
                end
                if (o_valid) begin
                    if (capq.size() > 0 && capq[0].edge_n == cyc) begin
                        check("cap_word", o_word, capq[0].word);
                        check("cap_select", 32'(o_sel), 32'(capq[0].src));
                        check("cap_index", 32'(o_idx), 32'(capq[0].src));
                        mword = capq[0].word;
                        void'(capq.pop_front());
                    end else begin
                        check("unexpected_capture_valid", 32'(o_valid), 32'h0);
                    end
                end
            end
            if (seen) begin
                int dig;
                logic [7:0] an;
                dig = (k / DC) % 8;
                an = 8'hFF;
                an[dig] = 1'b0;
                check("captured_word", o_word, mword);
                check("anode", 32'(o_anode), 32'(an));
                check("segments", 32'(o_seg), 32'(exp_seg(mword, dig)));
            end
        end
    end

    initial begin
        logic [4:0] m;
        bit a;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5'd0, 32'h0000_0101);
        for (int i = 0; i < 2 * PER; i++) step(1'b0, 1'b1, 5'd0, 32'h0000_0101);
        for (int i = 0; i < 13 * PER; i++) step(1'b0, 1'b1, 5'd0, pick_hex());
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 5'd3, pick_hex());
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 5'd20, pick_hex());
        m = 5'd20;
        a = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) m = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 63) == 0) a = ~a;
            step(1'b0, a, m, pick_hex());
        end
        for (int i = 0; i < 2 * PER + 2; i++) begin
            if ((cyc + 1) - sel_edge == 1) break;
            step(1'b0, 1'b1, 5'd0, pick_hex());
        end
        step(1'b1, 1'b1, 5'd0, 32'hAAAA_BBBB);
        for (int i = 0; i < 4 * PER; i++) step(1'b0, 1'b1, 5'd0, 32'hAAAA_BBBB);
        for (int i = 0; i < 4 * PER; i++) step(1'b0, 1'b1, 5'd0, 32'h0000_2626);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd25, 32'h0);
        for (int i = 0; i < 3 * PER; i++) step(1'b0, 1'b0, 5'd25, pick_hex());
        @(posedge clk);
        #1;
        check("queue_drained", 32'(capq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
